// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// multicycle_ctrl : fetch/decode/exec/mem/wb sequencer for the 64-bit datapath
// Optional feature macro: OVERFLOW_TRAP_EN (R-type overflow -> TRAP state)
// Revision: 1.0
// ============================================================================
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             overflow,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic [1:0]       aluop,
  output logic             alu_src,
  output logic             dmem_rd,
  output logic             dmem_wr,
  output logic             rf_we,
  output logic             mem_to_reg,
  output logic [2:0]       state,
  output logic             illegal,
  output logic             bus_err,
  output logic             trap,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  typedef enum logic [1:0] {C_R = 2'd0, C_LD = 2'd1, C_SD = 2'd2, C_BEQ = 2'd3} cls_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  cls_t             cls_q, cls_d;
  logic [7:0]       wait_q, wait_d;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;
  logic             trap_q, trap_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      cls_q     <= C_R;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      trap_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
      trap_q    <= trap_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    wait_d     = wait_q;
    illegal_d  = illegal_q;
    bus_err_d  = bus_err_q;
    trap_d     = trap_q;
    retired_d  = retired_q;
    retire     = 1'b0;
    imem_req   = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 1'b0;
    aluop      = 2'b00;
    alu_src    = 1'b0;
    dmem_rd    = 1'b0;
    dmem_wr    = 1'b0;
    rf_we      = 1'b0;
    mem_to_reg = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        state_d = S_EXEC;
        case (opcode)
          OP_R:    cls_d = C_R;
          OP_LD:   cls_d = C_LD;
          OP_SD:   cls_d = C_SD;
          OP_BEQ:  cls_d = C_BEQ;
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EXEC: begin
        case (cls_q)
          C_R: begin
            aluop = 2'b10;
`ifdef OVERFLOW_TRAP_EN
            if (overflow) begin
              state_d = S_TRAP;
              trap_d  = 1'b1;
            end else begin
              state_d = S_WB;
            end
`else
            state_d = S_WB;
`endif
          end
          C_LD, C_SD: begin
            alu_src = 1'b1;
            state_d = S_MEM;
          end
          default: begin
            aluop   = 2'b01;
            pc_we   = 1'b1;
            pc_src  = zero;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        alu_src = 1'b1;
        dmem_rd = (cls_q == C_LD);
        dmem_wr = (cls_q == C_SD);
        // An ack on the last allowed cycle beats the timeout.
        if (dmem_ack) begin
          if (cls_q == C_LD) begin
            state_d = S_WB;
          end else begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB: begin
        rf_we      = 1'b1;
        mem_to_reg = (cls_q == C_LD);
        alu_src    = (cls_q == C_LD);
        aluop      = (cls_q == C_R) ? 2'b10 : 2'b00;
        pc_we      = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      default: ;
    endcase

    if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM)))
      wait_d = '0;

    if (retire && (retired_q != {CNT_W{1'b1}}))
      retired_d = retired_q + CNT_W'(1);

    // Nothing may reach the datapath or memories while reset is held.
    if (!rst) begin
      imem_req   = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_src     = 1'b0;
      aluop      = 2'b00;
      alu_src    = 1'b0;
      dmem_rd    = 1'b0;
      dmem_wr    = 1'b0;
      rf_we      = 1'b0;
      mem_to_reg = 1'b0;
    end
  end

`ifndef OVERFLOW_TRAP_EN
  logic unused_overflow;
  assign unused_overflow = overflow;
`endif

  assign state   = state_q;
  assign illegal = illegal_q;
  assign bus_err = bus_err_q;
  assign trap    = trap_q;
  assign retired = retired_q;

endmodule
`default_nettype wire
